// File: rtl/decode_stage_if.sv
// decode_stage_if
//   Bundles every non-clock signal of the MIPS instruction-decode stage.
//   Signal names are those the surrounding pipeline already uses.
//
//   Handshake: there is none. The stage has no valid/ready pair and no
//   stall/flush. Every rising clk edge latches whatever is on the IF/ID and
//   MEM/WB signals, and the ID/EX outputs change once per edge.
//
//   Modports
//     master : the surrounding pipeline (drives IF/ID and MEM/WB, reads ID/EX)
//     slave  : decode_stage itself
interface decode_stage_if;
  // IF/ID inputs
  logic [31:0] IF_ID_instrout;
  logic [31:0] IF_ID_npcout;
  // MEM/WB write-back inputs
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite;
  logic [31:0] WB_mux5_writedata;
  // ID/EX outputs
  logic [1:0]  wb_ctlout;        // {regwrite, memtoreg}
  logic [2:0]  m_ctlout;         // {branch, memread, memwrite}
  logic        regdst;
  logic        alusrc;
  logic [1:0]  aluop;
  logic [31:0] npcout;
  logic [31:0] rdata1out;
  logic [31:0] rdata2out;
  logic [31:0] s_extendout;
  logic [4:0]  instrout_2016;
  logic [4:0]  instrout_1511;

  modport master (
    output IF_ID_instrout, IF_ID_npcout,
    output MEM_WB_rd, MEM_WB_regwrite, WB_mux5_writedata,
    input  wb_ctlout, m_ctlout, regdst, alusrc, aluop,
    input  npcout, rdata1out, rdata2out, s_extendout,
    input  instrout_2016, instrout_1511
  );

  modport slave (
    input  IF_ID_instrout, IF_ID_npcout,
    input  MEM_WB_rd, MEM_WB_regwrite, WB_mux5_writedata,
    output wb_ctlout, m_ctlout, regdst, alusrc, aluop,
    output npcout, rdata1out, rdata2out, s_extendout,
    output instrout_2016, instrout_1511
  );
endinterface

// File: rtl/decode_stage.sv
// decode_stage
//   MIPS-I instruction-decode stage: main control decoder, 32x32 register
//   file (two combinational reads, one clocked write from MEM/WB), 16->32
//   sign extender and the ID/EX pipeline register.
//
//   Ports
//     clk : rising-edge clock, only clock domain
//     rst : synchronous active-high reset; clears the register file and
//           forces every ID/EX output to 0 (a bubble)
//     id  : decode_stage_if.slave, IF/ID + MEM/WB inputs, ID/EX outputs
module decode_stage (
  input  logic           clk,
  input  logic           rst,
  decode_stage_if.slave  id
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // Instruction fields
  logic [5:0]  opcode;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [15:0] imm;

  assign opcode = id.IF_ID_instrout[31:26];
  assign rs     = id.IF_ID_instrout[25:21];
  assign rt     = id.IF_ID_instrout[20:16];
  assign rd     = id.IF_ID_instrout[15:11];
  assign imm    = id.IF_ID_instrout[15:0];

  // ---------------------------------------------------------------------
  // Main control decoder
  // ---------------------------------------------------------------------
  logic       c_regdst;
  logic [1:0] c_aluop;
  logic       c_alusrc;
  logic [2:0] c_m;
  logic [1:0] c_wb;

  always_comb begin
    // Unknown opcodes decode to an all-zero bubble: no write, no memory
    // access, no branch.
    c_regdst = 1'b0;
    c_aluop  = 2'b00;
    c_alusrc = 1'b0;
    c_m      = 3'b000;
    c_wb     = 2'b00;
    case (opcode)
      OP_RTYPE: begin
        c_regdst = 1'b1;
        c_aluop  = 2'b10;
        c_wb     = 2'b10;
      end
      OP_LW: begin
        c_alusrc = 1'b1;
        c_m      = 3'b010;
        c_wb     = 2'b11;
      end
      OP_SW: begin
        c_alusrc = 1'b1;
        c_m      = 3'b001;
      end
      OP_BEQ: begin
        c_aluop  = 2'b01;
        c_m      = 3'b100;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------
  // Register file
  // ---------------------------------------------------------------------
  logic [31:0] regs [32];
  logic        wr_en;

  // Writes to $0 are dropped so $0 never holds anything but zero.
  assign wr_en = id.MEM_WB_regwrite && (id.MEM_WB_rd != 5'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[id.MEM_WB_rd] <= id.WB_mux5_writedata;
    end
  end

  // Reads bypass a same-cycle write so a dependent instruction three
  // stages behind its producer sees the new value without a stall.
  logic [31:0] rdata_a;
  logic [31:0] rdata_b;

  always_comb begin
    if (rs == 5'd0)                          rdata_a = '0;
    else if (wr_en && (id.MEM_WB_rd == rs))  rdata_a = id.WB_mux5_writedata;
    else                                     rdata_a = regs[rs];
  end

  always_comb begin
    if (rt == 5'd0)                          rdata_b = '0;
    else if (wr_en && (id.MEM_WB_rd == rt))  rdata_b = id.WB_mux5_writedata;
    else                                     rdata_b = regs[rt];
  end

  // ---------------------------------------------------------------------
  // Sign extender
  // ---------------------------------------------------------------------
  logic [31:0] s_ext;
  assign s_ext = {{16{imm[15]}}, imm};

  // ---------------------------------------------------------------------
  // ID/EX pipeline register (loads every cycle, reset inserts a bubble)
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      id.wb_ctlout     <= '0;
      id.m_ctlout      <= '0;
      id.regdst        <= 1'b0;
      id.alusrc        <= 1'b0;
      id.aluop         <= '0;
      id.npcout        <= '0;
      id.rdata1out     <= '0;
      id.rdata2out     <= '0;
      id.s_extendout   <= '0;
      id.instrout_2016 <= '0;
      id.instrout_1511 <= '0;
    end else begin
      id.wb_ctlout     <= c_wb;
      id.m_ctlout      <= c_m;
      id.regdst        <= c_regdst;
      id.alusrc        <= c_alusrc;
      id.aluop         <= c_aluop;
      id.npcout        <= id.IF_ID_npcout;
      id.rdata1out     <= rdata_a;
      id.rdata2out     <= rdata_b;
      id.s_extendout   <= s_ext;
      id.instrout_2016 <= rt;
      id.instrout_1511 <= rd;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  decode_stage_if bus ();

  decode_stage dut (
    .clk (clk),
    .rst (rst),
    .id  (bus)
  );

  // ---------------- scoreboard ----------------
  int n_checks;
  int n_fails;
  logic [31:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] obs,
                          input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wb(input logic en, input logic [4:0] rd,
                        input logic [31:0] data);
    bus.MEM_WB_regwrite   = en;
    bus.MEM_WB_rd         = rd;
    bus.WB_mux5_writedata = data;
  endtask

  task automatic set_if(input logic [31:0] instr, input logic [31:0] npc);
    bus.IF_ID_instrout = instr;
    bus.IF_ID_npcout   = npc;
  endtask

  // {regdst, aluop, alusrc}, M and WB fields in one call
  task automatic check_ctl(input string tag, input logic [3:0] ex,
                           input logic [2:0] m, input logic [1:0] wb);
    check_eq({tag, ".ex"}, {28'd0, bus.regdst, bus.aluop, bus.alusrc}, {28'd0, ex});
    check_eq({tag, ".m"},  {29'd0, bus.m_ctlout}, {29'd0, m});
    check_eq({tag, ".wb"}, {30'd0, bus.wb_ctlout}, {30'd0, wb});
  endtask

  task automatic check_all_zero(input string tag);
    check_ctl(tag, 4'b0000, 3'b000, 2'b00);
    check_eq({tag, ".npc"},  bus.npcout, 32'h0);
    check_eq({tag, ".rd1"},  bus.rdata1out, 32'h0);
    check_eq({tag, ".rd2"},  bus.rdata2out, 32'h0);
    check_eq({tag, ".sext"}, bus.s_extendout, 32'h0);
    check_eq({tag, ".rt"},   {27'd0, bus.instrout_2016}, 32'h0);
    check_eq({tag, ".rdf"},  {27'd0, bus.instrout_1511}, 32'h0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] r;
    n_checks = 0;
    n_fails  = 0;
    rst = 1'b1;
    set_if(32'h0, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();

    // Preload some registers so the reset clear is observable.
    rst = 1'b0;
    set_wb(1'b1, 5'd5, 32'hAAAA_5555);
    tick();
    set_wb(1'b1, 5'd31, 32'h1357_9BDF);
    tick();

    // 1. Reset for two cycles with a live instruction and a coincident write.
    rst = 1'b1;
    set_if(32'h0109_5020, 32'h0000_0040);
    set_wb(1'b1, 5'd7, 32'hCAFE_F00D);
    tick();
    tick();
    check_all_zero("reset");
    rst = 1'b0;
    set_wb(1'b0, 5'd0, 32'h0);

    // Every register reads zero after reset on both ports.
    for (int i = 0; i < 32; i++) begin
      r = 5'(i);
      set_if({6'b0, r, r, 16'h0020}, 32'h0);
      tick();
      check_eq($sformatf("rst_clr_a[%0d]", i), bus.rdata1out, 32'h0);
      check_eq($sformatf("rst_clr_b[%0d]", i), bus.rdata2out, 32'h0);
    end

    // 2. Write reg 8, then add $10,$8,$9.
    set_wb(1'b1, 5'd8, 32'hDEAD_BEEF);
    tick();
    set_wb(1'b0, 5'd0, 32'h0);
    set_if(32'h0109_5020, 32'h0000_0004);
    tick();
    check_eq("add.rd1", bus.rdata1out, 32'hDEAD_BEEF);
    check_eq("add.rd2", bus.rdata2out, 32'h0);
    check_ctl("add", 4'b1100, 3'b000, 2'b10);
    check_eq("add.rdf", {27'd0, bus.instrout_1511}, 32'd10);
    check_eq("add.rt",  {27'd0, bus.instrout_2016}, 32'd9);
    check_eq("add.npc", bus.npcout, 32'h4);
    check_eq("add.sext", bus.s_extendout, 32'h0000_5020);

    // 3. lw $9,-4($8)
    set_if(32'h8D09_FFFC, 32'h0000_0008);
    tick();
    check_eq("lw.sext", bus.s_extendout, 32'hFFFF_FFFC);
    check_ctl("lw", 4'b0001, 3'b010, 2'b11);
    check_eq("lw.rt",  {27'd0, bus.instrout_2016}, 32'd9);
    check_eq("lw.rd1", bus.rdata1out, 32'hDEAD_BEEF);
    check_eq("lw.npc", bus.npcout, 32'h8);

    // 4. Writes to $0 are ignored, also when bypass would apply.
    set_wb(1'b1, 5'd0, 32'h0000_1234);
    set_if(32'h0000_0020, 32'h0);
    tick();
    check_eq("r0_byp.rd1", bus.rdata1out, 32'h0);
    check_eq("r0_byp.rd2", bus.rdata2out, 32'h0);
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check_eq("r0_read.rd1", bus.rdata1out, 32'h0);

    // 5. Same-cycle write to reg 9 while reading rt=9 (port B bypass).
    set_wb(1'b1, 5'd9, 32'h0000_0055);
    set_if(32'h0109_5020, 32'h0000_000C);
    tick();
    check_eq("byp_b.rd2", bus.rdata2out, 32'h0000_0055);
    check_eq("byp_b.rd1", bus.rdata1out, 32'hDEAD_BEEF);
    // Port A bypass: overwrite reg 8 while reading rs=8.
    set_wb(1'b1, 5'd8, 32'h0000_0077);
    tick();
    check_eq("byp_a.rd1", bus.rdata1out, 32'h0000_0077);
    check_eq("byp_a.rd2", bus.rdata2out, 32'h0000_0055);
    // Both values persisted in the array.
    set_wb(1'b0, 5'd0, 32'h0);
    tick();
    check_eq("held.rd1", bus.rdata1out, 32'h0000_0077);
    check_eq("held.rd2", bus.rdata2out, 32'h0000_0055);
    // Earlier preloaded regs 5/31 must still read 0 after the reset.
    set_if({6'b0, 5'd5, 5'd31, 16'h0}, 32'h0);
    tick();
    check_eq("pre_rst5", bus.rdata1out, 32'h0);
    check_eq("pre_rst31", bus.rdata2out, 32'h0);

    // 6. Unknown opcode, sw and beq.
    set_if(32'hFD09_5020, 32'h0000_0010);
    tick();
    check_ctl("op3f", 4'b0000, 3'b000, 2'b00);
    set_if(32'hAD09_0004, 32'h0000_0014);
    tick();
    check_ctl("sw", 4'b0001, 3'b001, 2'b00);
    check_eq("sw.sext", bus.s_extendout, 32'h4);
    set_if(32'h1109_0002, 32'h0000_0018);
    tick();
    check_ctl("beq", 4'b0010, 3'b100, 2'b00);
    check_eq("beq.sext", bus.s_extendout, 32'h2);
    check_eq("beq.npc", bus.npcout, 32'h18);

    // Mid-stream reset discards the lw being latched and clears registers.
    rst = 1'b1;
    set_if(32'h8D09_FFFC, 32'h0000_001C);
    tick();
    check_all_zero("mid_rst");
    rst = 1'b0;
    set_if(32'h0109_5020, 32'h0000_0020);
    tick();
    check_eq("post_rst.rd1", bus.rdata1out, 32'h0);
    check_eq("post_rst.rd2", bus.rdata2out, 32'h0);
    check_ctl("post_rst", 4'b1100, 3'b000, 2'b10);

    // ---------------- final report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
